// File: rtl/sec_zone_alarm_ctrl_pkg.sv
// Shared types for the multi-zone security alarm controller.
// State encoding and counter width helper.
package sec_alarm_pkg;

    typedef enum logic [2:0] {
        DISARMED = 3'd0,
        EXIT     = 3'd1,
        ARMED    = 3'd2,
        ENTRY    = 3'd3,
        ALARM    = 3'd4
    } state_t;

    // Width of the shared down-counter: enough to hold the largest delay.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sec_zone_alarm_ctrl_if.sv
// Sensor/keypad/siren bundle for sec_zone_alarm_ctrl.
// Optional tamper line exists only with SEC_ALARM_TAMPER_EN defined.
interface sec_zone_alarm_ctrl_if #(
    parameter int NUM_ZONES = 4
);
    logic                 arm;
    logic                 disarm;
    logic [NUM_ZONES-1:0] zone_mask;
    logic [NUM_ZONES-1:0] instant_mask;
    logic [NUM_ZONES-1:0] sensor;
`ifdef SEC_ALARM_TAMPER_EN
    logic                 tamper;
`endif
    logic                 alarm;
    logic [2:0]           state_o;
    logic [NUM_ZONES-1:0] tripped_zones;

    modport master (
        output arm, disarm, zone_mask, instant_mask, sensor,
`ifdef SEC_ALARM_TAMPER_EN
        output tamper,
`endif
        input  alarm, state_o, tripped_zones
    );

    modport slave (
        input  arm, disarm, zone_mask, instant_mask, sensor,
`ifdef SEC_ALARM_TAMPER_EN
        input  tamper,
`endif
        output alarm, state_o, tripped_zones
    );

endinterface

// File: rtl/sec_delay_timer.sv
// Loadable down-counter shared by the EXIT, ENTRY and ALARM states.
// Saturates at zero; load has priority over decrement.
module sec_delay_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    // Count register: load, else decrement while enabled and non-zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sec_zone_alarm_ctrl.sv
// Multi-zone arm/sense/alarm controller driving a registered siren.
// Optional tamper input enabled by defining SEC_ALARM_TAMPER_EN.
module sec_zone_alarm_ctrl
    import sec_alarm_pkg::*;
#(
    parameter int NUM_ZONES    = 4,
    parameter int EXIT_DLY     = 3,
    parameter int ENTRY_DLY    = 5,
    parameter int ALARM_CYCLES = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    sec_zone_alarm_ctrl_if.slave bus
);

    localparam int CW = cnt_width(EXIT_DLY, ENTRY_DLY, ALARM_CYCLES);
    localparam int ALARM_LD = (ALARM_CYCLES == 0) ? 0 : ALARM_CYCLES - 1;

    localparam logic [CW-1:0] EXIT_VAL  = CW'(EXIT_DLY);
    localparam logic [CW-1:0] ENTRY_VAL = CW'(ENTRY_DLY);
    localparam logic [CW-1:0] ALARM_VAL = CW'(ALARM_LD);

    state_t               state;
    state_t               next_state;
    logic                 alarm_q;
    logic [NUM_ZONES-1:0] tripped;

    logic                 load;
    logic [CW-1:0]        load_val;
    logic                 en;
    logic                 zero;
    logic [NUM_ZONES-1:0] trip_set;
    logic                 trip_clr;

    logic [NUM_ZONES-1:0] hit;
    logic                 any_hit;
    logic                 inst_hit;

    assign hit      = bus.sensor & bus.zone_mask;
    assign any_hit  = |hit;
    assign inst_hit = |(hit & bus.instant_mask);

    sec_delay_timer #(
        .W(CW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .zero     (zero)
    );

    // Next-state, timer control and trip-record update.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_val   = '0;
        en         = 1'b0;
        trip_set   = '0;
        trip_clr   = 1'b0;

        case (state)
            DISARMED: begin
                if (bus.arm && !bus.disarm) begin
                    next_state = EXIT;
                    load       = 1'b1;
                    load_val   = EXIT_VAL;
                    trip_clr   = 1'b1;
                end
            end
            EXIT: begin
                if (bus.disarm) begin
                    next_state = DISARMED;
                end else if (zero) begin
                    next_state = ARMED;
                end else begin
                    en = 1'b1;
                end
            end
            ARMED: begin
                if (bus.disarm) begin
                    next_state = DISARMED;
                end else begin
                    trip_set = hit;
                    if (inst_hit) begin
                        next_state = ALARM;
                        load       = 1'b1;
                        load_val   = ALARM_VAL;
                    end else if (any_hit) begin
                        next_state = ENTRY;
                        load       = 1'b1;
                        load_val   = ENTRY_VAL;
                    end
                end
            end
            ENTRY: begin
                if (bus.disarm) begin
                    next_state = DISARMED;
                end else begin
                    trip_set = hit;
                    if (inst_hit || zero) begin
                        next_state = ALARM;
                        load       = 1'b1;
                        load_val   = ALARM_VAL;
                    end else begin
                        en = 1'b1;
                    end
                end
            end
            ALARM: begin
                if (bus.disarm) begin
                    next_state = DISARMED;
                end else begin
                    trip_set = hit;
                    if ((ALARM_CYCLES != 0) && zero) begin
                        next_state = ARMED;
                    end else begin
                        en = 1'b1;
                    end
                end
            end
            default: begin
                next_state = DISARMED;
            end
        endcase

`ifdef SEC_ALARM_TAMPER_EN
        // Tamper forces the siren and blocks disarm and auto-rearm.
        if (bus.tamper) begin
            next_state = ALARM;
            trip_set   = '0;
            trip_clr   = 1'b0;
            if (state != ALARM) begin
                load     = 1'b1;
                load_val = ALARM_VAL;
                en       = 1'b0;
            end else begin
                load     = 1'b0;
                load_val = '0;
                en       = 1'b1;
            end
        end
`endif
    end

    // State, siren and trip record registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= DISARMED;
            alarm_q <= 1'b0;
            tripped <= '0;
        end else begin
            state   <= next_state;
            alarm_q <= (next_state == ALARM);
            if (trip_clr) begin
                tripped <= '0;
            end else begin
                tripped <= tripped | trip_set;
            end
        end
    end

    assign bus.alarm         = alarm_q;
    assign bus.state_o       = state;
    assign bus.tripped_zones = tripped;

endmodule

// File: tb/tb_sec_zone_alarm_ctrl.sv
// Self-checking bench for sec_zone_alarm_ctrl (4 zones, 3/5/8 delays).
// Expected results queue in a scoreboard as each cycle is driven.
module tb_sec_zone_alarm_ctrl;
    import sec_alarm_pkg::*;

    typedef struct {
        logic       arm;
        logic       disarm;
        logic [3:0] sensor;
        logic [3:0] zmask;
        logic [2:0] st;
        logic       al;
        logic [3:0] tz;
    } step_t;

    typedef struct {
        logic [2:0] st;
        logic       al;
        logic [3:0] tz;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    exp_t sb[$];
    logic [3:0] cur_im;
    logic       cur_tp;

    sec_zone_alarm_ctrl_if #(.NUM_ZONES(4)) bus ();

    sec_zone_alarm_ctrl #(
        .NUM_ZONES    (4),
        .EXIT_DLY     (3),
        .ENTRY_DLY    (5),
        .ALARM_CYCLES (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic step_t mk(input logic a, input logic d,
                                 input logic [3:0] s, input logic [3:0] zm,
                                 input logic [2:0] st, input logic al,
                                 input logic [3:0] tz);
        step_t r;
        r.arm = a; r.disarm = d; r.sensor = s; r.zmask = zm;
        r.st = st; r.al = al; r.tz = tz;
        return r;
    endfunction

    task automatic drive(input step_t s);
        exp_t e;
        @(negedge clk);
        bus.arm          = s.arm;
        bus.disarm       = s.disarm;
        bus.sensor       = s.sensor;
        bus.zone_mask    = s.zmask;
        bus.instant_mask = cur_im;
`ifdef SEC_ALARM_TAMPER_EN
        bus.tamper       = cur_tp;
`endif
        e.st = s.st; e.al = s.al; e.tz = s.tz;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.state_o, bus.alarm, bus.tripped_zones} !== 8'h00) begin
            errors++;
            $display("FAIL reset: st=%0d al=%0b tz=%h want st=0 al=0 tz=0",
                     bus.state_o, bus.alarm, bus.tripped_zones);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_arm_exit();
        step_t q[$];
        exp_t  e;
        cur_im = 4'h0;
        q.push_back(mk(1, 0, 4'h0, 4'hF, EXIT, 0, 4'h0));
        for (int i = 0; i < 3; i++)
            q.push_back(mk(0, 0, 4'h0, 4'hF, EXIT, 0, 4'h0));
        for (int i = 0; i < 2; i++)
            q.push_back(mk(0, 0, 4'h0, 4'hF, ARMED, 0, 4'h0));
        foreach (q[i]) begin
            drive(q[i]);
            e = sb.pop_front();
            checks++;
            if ({bus.state_o, bus.alarm, bus.tripped_zones} !==
                {e.st, e.al, e.tz}) begin
                errors++;
                $display("FAIL arm_exit[%0d]: st=%0d al=%0b tz=%h want st=%0d al=%0b tz=%h",
                         i, bus.state_o, bus.alarm, bus.tripped_zones,
                         e.st, e.al, e.tz);
            end
        end
    endtask

    task automatic test_delayed();
        step_t q[$];
        exp_t  e;
        cur_im = 4'h0;
        q.push_back(mk(0, 0, 4'h2, 4'hF, ENTRY, 0, 4'h2));
        for (int i = 0; i < 5; i++)
            q.push_back(mk(0, 0, 4'h0, 4'hF, ENTRY, 0, 4'h2));
        q.push_back(mk(0, 0, 4'h0, 4'hF, ALARM, 1, 4'h2));
        q.push_back(mk(0, 0, 4'h0, 4'hF, ALARM, 1, 4'h2));
        q.push_back(mk(0, 1, 4'h0, 4'hF, DISARMED, 0, 4'h2));
        foreach (q[i]) begin
            drive(q[i]);
            e = sb.pop_front();
            checks++;
            if ({bus.state_o, bus.alarm, bus.tripped_zones} !==
                {e.st, e.al, e.tz}) begin
                errors++;
                $display("FAIL delayed[%0d]: st=%0d al=%0b tz=%h want st=%0d al=%0b tz=%h",
                         i, bus.state_o, bus.alarm, bus.tripped_zones,
                         e.st, e.al, e.tz);
            end
        end
    endtask

    task automatic test_instant();
        step_t q[$];
        exp_t  e;
        cur_im = 4'h1;
        q.push_back(mk(1, 0, 4'h0, 4'hF, EXIT, 0, 4'h0));
        for (int i = 0; i < 3; i++)
            q.push_back(mk(0, 0, 4'hF, 4'hF, EXIT, 0, 4'h0));
        q.push_back(mk(0, 0, 4'hF, 4'hF, ARMED, 0, 4'h0));
        q.push_back(mk(0, 0, 4'h1, 4'hE, ARMED, 0, 4'h0));
        q.push_back(mk(0, 0, 4'h1, 4'hF, ALARM, 1, 4'h1));
        for (int i = 0; i < 7; i++)
            q.push_back(mk(0, 0, 4'h0, 4'hF, ALARM, 1, 4'h1));
        for (int i = 0; i < 2; i++)
            q.push_back(mk(0, 0, 4'h0, 4'hF, ARMED, 0, 4'h1));
        foreach (q[i]) begin
            drive(q[i]);
            e = sb.pop_front();
            checks++;
            if ({bus.state_o, bus.alarm, bus.tripped_zones} !==
                {e.st, e.al, e.tz}) begin
                errors++;
                $display("FAIL instant[%0d]: st=%0d al=%0b tz=%h want st=%0d al=%0b tz=%h",
                         i, bus.state_o, bus.alarm, bus.tripped_zones,
                         e.st, e.al, e.tz);
            end
        end
    endtask

    task automatic test_entry_disarm();
        step_t q[$];
        exp_t  e;
        cur_im = 4'h1;
        q.push_back(mk(0, 0, 4'h2, 4'hF, ENTRY, 0, 4'h3));
        for (int i = 0; i < 3; i++)
            q.push_back(mk(0, 0, 4'h0, 4'hF, ENTRY, 0, 4'h3));
        q.push_back(mk(0, 1, 4'h0, 4'hF, DISARMED, 0, 4'h3));
        for (int i = 0; i < 6; i++)
            q.push_back(mk(0, 0, 4'h0, 4'hF, DISARMED, 0, 4'h3));
        foreach (q[i]) begin
            drive(q[i]);
            e = sb.pop_front();
            checks++;
            if ({bus.state_o, bus.alarm, bus.tripped_zones} !==
                {e.st, e.al, e.tz}) begin
                errors++;
                $display("FAIL entry_disarm[%0d]: st=%0d al=%0b tz=%h want st=%0d al=%0b tz=%h",
                         i, bus.state_o, bus.alarm, bus.tripped_zones,
                         e.st, e.al, e.tz);
            end
        end
    endtask

    task automatic test_arm_disarm_same();
        step_t q[$];
        exp_t  e;
        cur_im = 4'h0;
        q.push_back(mk(1, 1, 4'h0, 4'hF, DISARMED, 0, 4'h3));
        q.push_back(mk(0, 0, 4'h0, 4'hF, DISARMED, 0, 4'h3));
        foreach (q[i]) begin
            drive(q[i]);
            e = sb.pop_front();
            checks++;
            if ({bus.state_o, bus.alarm, bus.tripped_zones} !==
                {e.st, e.al, e.tz}) begin
                errors++;
                $display("FAIL arm_disarm[%0d]: st=%0d al=%0b tz=%h want st=%0d al=%0b tz=%h",
                         i, bus.state_o, bus.alarm, bus.tripped_zones,
                         e.st, e.al, e.tz);
            end
        end
    endtask

    task automatic test_reset_mid_alarm();
        step_t q[$];
        exp_t  e;
        cur_im = 4'h1;
        q.push_back(mk(1, 0, 4'h0, 4'hF, EXIT, 0, 4'h0));
        for (int i = 0; i < 3; i++)
            q.push_back(mk(0, 0, 4'h0, 4'hF, EXIT, 0, 4'h0));
        q.push_back(mk(0, 0, 4'h0, 4'hF, ARMED, 0, 4'h0));
        q.push_back(mk(0, 0, 4'h1, 4'hF, ALARM, 1, 4'h1));
        q.push_back(mk(0, 0, 4'h0, 4'hF, ALARM, 1, 4'h1));
        foreach (q[i]) begin
            drive(q[i]);
            e = sb.pop_front();
            checks++;
            if ({bus.state_o, bus.alarm, bus.tripped_zones} !==
                {e.st, e.al, e.tz}) begin
                errors++;
                $display("FAIL rst_prep[%0d]: st=%0d al=%0b tz=%h want st=%0d al=%0b tz=%h",
                         i, bus.state_o, bus.alarm, bus.tripped_zones,
                         e.st, e.al, e.tz);
            end
        end
        @(negedge clk);
        rst_n = 1'b0;
        e.st = DISARMED; e.al = 1'b0; e.tz = 4'h0;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        checks++;
        if ({bus.state_o, bus.alarm, bus.tripped_zones} !==
            {e.st, e.al, e.tz}) begin
            errors++;
            $display("FAIL rst_async: st=%0d al=%0b tz=%h want st=%0d al=%0b tz=%h",
                     bus.state_o, bus.alarm, bus.tripped_zones,
                     e.st, e.al, e.tz);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        q.push_back(mk(0, 0, 4'h1, 4'hF, DISARMED, 0, 4'h0));
        foreach (q[i]) begin
            drive(q[i]);
            e = sb.pop_front();
            checks++;
            if ({bus.state_o, bus.alarm, bus.tripped_zones} !==
                {e.st, e.al, e.tz}) begin
                errors++;
                $display("FAIL rst_after[%0d]: st=%0d al=%0b tz=%h want st=%0d al=%0b tz=%h",
                         i, bus.state_o, bus.alarm, bus.tripped_zones,
                         e.st, e.al, e.tz);
            end
        end
    endtask

`ifdef SEC_ALARM_TAMPER_EN
    task automatic test_tamper();
        step_t q[$];
        logic  tp[$];
        exp_t  e;
        cur_im = 4'h0;
        q.push_back(mk(0, 0, 4'h0, 4'hF, ALARM, 1, 4'h0));    tp.push_back(1'b1);
        q.push_back(mk(0, 1, 4'h4, 4'hF, ALARM, 1, 4'h0));    tp.push_back(1'b1);
        q.push_back(mk(0, 1, 4'h0, 4'hF, DISARMED, 0, 4'h0)); tp.push_back(1'b0);
        foreach (q[i]) begin
            cur_tp = tp[i];
            drive(q[i]);
            e = sb.pop_front();
            checks++;
            if ({bus.state_o, bus.alarm, bus.tripped_zones} !==
                {e.st, e.al, e.tz}) begin
                errors++;
                $display("FAIL tamper[%0d]: st=%0d al=%0b tz=%h want st=%0d al=%0b tz=%h",
                         i, bus.state_o, bus.alarm, bus.tripped_zones,
                         e.st, e.al, e.tz);
            end
        end
        cur_tp = 1'b0;
    endtask
`endif

    initial begin
        errors           = 0;
        checks           = 0;
        cur_im           = 4'h0;
        cur_tp           = 1'b0;
        rst_n            = 1'b0;
        bus.arm          = 1'b0;
        bus.disarm       = 1'b0;
        bus.sensor       = 4'h0;
        bus.zone_mask    = 4'hF;
        bus.instant_mask = 4'h0;
`ifdef SEC_ALARM_TAMPER_EN
        bus.tamper       = 1'b0;
`endif
        #1;
        test_reset();
        test_arm_exit();
        test_delayed();
        test_instant();
        test_entry_disarm();
        test_arm_disarm_same();
        test_reset_mid_alarm();
`ifdef SEC_ALARM_TAMPER_EN
        test_tamper();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
